// File: rtl/div_seq_if.sv
// Bundles the request/response handshakes, flush, and the borrowed ALU port of the
// divide sequencer.
interface div_seq_if #(parameter int WIDTH = 32);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       alu_sel;
  logic             alu_add_sub;
  logic             alu_s_u;
  logic             alu_a_l;
  logic             alu_l_r;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_less;

  modport slave (
    input  flush, in_valid, op, src1, src2, out_ready, alu_result, alu_less,
    output in_ready, out_valid, out_result,
    output alu_sel, alu_add_sub, alu_s_u, alu_a_l, alu_l_r, alu_a, alu_b
  );

  modport master (
    output flush, in_valid, op, src1, src2, out_ready, alu_result, alu_less,
    input  in_ready, out_valid, out_result,
    input  alu_sel, alu_add_sub, alu_s_u, alu_a_l, alu_l_r, alu_a, alu_b
  );
endinterface

// File: rtl/div_seq.sv
// RV32M DIV/DIVU/REM/REMU sequencer: restoring divide, one shared-ALU subtract per cycle.
//   state | meaning
//   IDLE  | waiting for a request
//   NEG_A | negate a negative signed dividend
//   NEG_B | negate a negative signed divisor
//   STEP  | 32 restoring divide iterations
//   FIX   | apply sign to quotient or remainder
//   DONE  | result held until consumer accepts
module div_seq #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst_n,
  div_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, NEG_A, NEG_B, STEP, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;

  logic [WIDTH-1:0] sh;
  logic             q_bit;
  logic             fix_req;
  logic             signed_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end

  assign signed_in = ~bus.op[0];
  assign fix_req   = ~op_q[0] & (op_q[1] ? sa_q : (sa_q ^ sb_q));

  always_comb begin
    state_d         = state_q;
    rem_d           = rem_q;
    quo_d           = quo_q;
    dvs_d           = dvs_q;
    cnt_d           = cnt_q;
    op_d            = op_q;
    sa_d            = sa_q;
    sb_d            = sb_q;
    bus.alu_a       = '0;
    bus.alu_b       = '0;
    bus.alu_add_sub = 1'b0;
    bus.alu_s_u     = 1'b0;
    sh              = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    // The bit shifted out of rem means the partial remainder already exceeds any divisor.
    q_bit           = rem_q[WIDTH-1] | ~bus.alu_less;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d  = bus.op;
          sa_d  = signed_in & bus.src1[WIDTH-1];
          sb_d  = signed_in & bus.src2[WIDTH-1];
          cnt_d = '0;
          if (bus.src2 == '0) begin
            rem_d   = bus.src1;
            quo_d   = '1;
            state_d = DONE;
          end else if (signed_in && bus.src1 == {1'b1, {(WIDTH-1){1'b0}}} && bus.src2 == '1) begin
            rem_d   = '0;
            quo_d   = {1'b1, {(WIDTH-1){1'b0}}};
            state_d = DONE;
          end else begin
            quo_d = bus.src1;
            dvs_d = bus.src2;
            rem_d = '0;
            if (signed_in && bus.src1[WIDTH-1])      state_d = NEG_A;
            else if (signed_in && bus.src2[WIDTH-1]) state_d = NEG_B;
            else                                     state_d = STEP;
          end
        end
      end
      NEG_A: begin
        bus.alu_b       = quo_q;
        bus.alu_add_sub = 1'b1;
        quo_d           = bus.alu_result;
        state_d         = sb_q ? NEG_B : STEP;
      end
      NEG_B: begin
        bus.alu_b       = dvs_q;
        bus.alu_add_sub = 1'b1;
        dvs_d           = bus.alu_result;
        state_d         = STEP;
      end
      STEP: begin
        bus.alu_a       = sh;
        bus.alu_b       = dvs_q;
        bus.alu_add_sub = 1'b1;
        bus.alu_s_u     = 1'b1;
        rem_d           = q_bit ? bus.alu_result : sh;
        quo_d           = {quo_q[WIDTH-2:0], q_bit};
        cnt_d           = cnt_q + 6'd1;
        if (cnt_q == 6'(WIDTH - 1)) state_d = fix_req ? FIX : DONE;
      end
      FIX: begin
        bus.alu_add_sub = 1'b1;
        if (op_q[1]) begin
          bus.alu_b = rem_q;
          rem_d     = bus.alu_result;
        end else begin
          bus.alu_b = quo_q;
          quo_d     = bus.alu_result;
        end
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush) begin
      state_d = IDLE;
      rem_d   = '0;
      quo_d   = '0;
      dvs_d   = '0;
      cnt_d   = '0;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_result = (state_q == DONE) ? (op_q[1] ? rem_q : quo_q) : '0;
  assign bus.alu_sel    = 3'b000;
  assign bus.alu_a_l    = 1'b0;
  assign bus.alu_l_r    = 1'b0;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq with a behavioural adder/comparator standing in for the ALU.
module tb_div_seq;
  logic clk;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;

  div_seq_if #(.WIDTH(32)) bus();

  div_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.alu_result = bus.alu_add_sub ? (bus.alu_a - bus.alu_b) : (bus.alu_a + bus.alu_b);
  assign bus.alu_less   = bus.alu_s_u ? (bus.alu_a < bus.alu_b)
                                      : ($signed(bus.alu_a) < $signed(bus.alu_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drives one request from the #1-after-edge phase; returns aligned the same way.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    bit busy_ok;
    bus.op       = o;
    bus.src1     = a;
    bus.src2     = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " in_ready low while busy"}, {31'd0, busy_ok & ~bus.in_ready}, 32'd1);
    check({tag, " result"}, bus.out_result, exp_res);
    if (bus.out_ready) begin
      @(posedge clk); #1;
      check({tag, " back to idle"}, {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    end
  endtask

  task automatic wait_cnt15(input logic [31:0] a, input logic [31:0] b);
    bus.op       = 2'b01;
    bus.src1     = a;
    bus.src2     = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.out_ready = 1'b1;
    #2;
    check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset out_result", bus.out_result, 32'd0);
    check("reset alu ctrl", {27'd0, bus.alu_sel, bus.alu_add_sub, bus.alu_s_u},
          32'd0);
    check("reset alu ops", bus.alu_a | bus.alu_b | {30'd0, bus.alu_a_l, bus.alu_l_r}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("DIVU 100/7", 2'b01, 32'd100, 32'd7, 32'h0000000E, 33);
    run_op("DIV -7/2", 2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 35);
    run_op("REM -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 35);
    run_op("REM 7/-2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 34);
    run_op("REM -7/-2", 2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 36);
    run_op("DIV -7/-2", 2'b00, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 35);
    run_op("DIVU max/1", 2'b01, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33);
    run_op("REMU max/msb", 2'b11, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 33);
    run_op("DIVU msb/max", 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
    run_op("DIVU 5/0", 2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op("REMU 5/0", 2'b11, 32'd5, 32'd0, 32'h00000005, 1);
    run_op("REM -7/0", 2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1);
    run_op("DIV ovf", 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("REM ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // Consumer back-pressure: result must hold, then a pending request is not taken
    // in the handshake cycle.
    bus.out_ready = 1'b0;
    run_op("stall DIVU 100/7", 2'b01, 32'd100, 32'd7, 32'h0000000E, 33);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall hold", {bus.out_valid, bus.in_ready, bus.out_result[29:0]},
            {1'b1, 1'b0, 30'h0000000E});
    end
    bus.op        = 2'b01;
    bus.src1      = 32'd50;
    bus.src2      = 32'd5;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("handshake no accept", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    @(posedge clk); #1;
    check("still idle", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);

    wait_cnt15(32'd1000, 32'd3);
    check("step alu ctrl", {27'd0, bus.alu_sel, bus.alu_add_sub, bus.alu_s_u, bus.alu_a_l, bus.alu_l_r},
          32'h0000000C);
    check("step busy", {31'd0, bus.in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("async reset", {29'd0, bus.in_ready, bus.out_valid, bus.alu_add_sub}, 32'd4);
    check("async reset result", bus.out_result, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    wait_cnt15(32'd1000, 32'd3);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush idle", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    check("flush result", bus.out_result, 32'd0);
    run_op("DIVU 9/3 after flush", 2'b01, 32'd9, 32'd3, 32'h00000003, 33);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d of %0d passed", passed, total);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle sequencer that executes RV32M DIV/DIVU/REM/REMU by time-multiplexing the core's shared 32-bit ALU adder. It runs a restoring divide, one subtract/compare per cycle. It sits beside the EXU: it accepts an operation over a valid/ready handshake, drives the ALU control and operand inputs itself for the duration, and returns the result over a second valid/ready handshake.

## Interface
- WIDTH, 32, operand width; only 32 is supported (must match the ALU)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort; returns to IDLE and drops any result
- in_valid  in  1  operation request
- in_ready  out  1  high only in IDLE
- op  in  2  op[0]=1 unsigned, op[1]=1 remainder (DIV=00, DIVU=01, REM=10, REMU=11)
- src1  in  32  dividend
- src2  in  32  divisor
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  32  quotient or remainder
- alu_sel  out  3  ALU function select; always 000 (adder)
- alu_add_sub  out  1  0 add / 1 subtract
- alu_s_u  out  1  compare mode; 1 unsigned
- alu_a_l, alu_l_r  out  1 each  tied 0
- alu_a, alu_b  out  32  ALU operands
- alu_result  in  32  ALU result (combinational, same cycle)
- alu_less  in  1  a<b under alu_s_u

## Operation
- States: IDLE, NEG_A, NEG_B, STEP, FIX, DONE.
- Signed means op[0]=0. Registers: rem, quo, dvs (32b each), cnt (6b), op_q, sa (sign of src1), sb (sign of src2).
- IDLE, on accept (in_valid & in_ready):
  - If src2==0: result = op[1] ? src1 : 32'hFFFFFFFF. Go to DONE.
  - Else if signed, src1==32'h80000000 and src2==32'hFFFFFFFF: result = op[1] ? 0 : 32'h80000000. Go to DONE.
  - Else latch quo=src1, dvs=src2, rem=0, cnt=0. Go to NEG_A if signed & src1[31]; else NEG_B if signed & src2[31]; else STEP.
- NEG_A: ALU a=0, b=quo, subtract. quo<=alu_result. Next is NEG_B if needed, else STEP.
- NEG_B: ALU a=0, b=dvs, subtract. dvs<=alu_result. Next is STEP.
- STEP (exactly 32 cycles):
  - sh={rem[30:0],quo[31]}, top=rem[31].
  - ALU a=sh, b=dvs, subtract, s_u=1.
  - q=top | ~alu_less. rem<=q ? alu_result : sh. quo<={quo[30:0],q}. cnt++.
  - After cnt reaches 31, next is FIX if required, else DONE.
- FIX is required when signed and either:
  - DIV with sa^sb: ALU 0-quo, quo<=alu_result; or
  - REM with sa: ALU 0-rem, rem<=alu_result.
  - Next is DONE.
- DONE: out_valid=1, out_result = op_q[1] ? rem : quo. Held stable until out_ready; then IDLE.
- Outside NEG_A/NEG_B/STEP/FIX, the ALU outputs are driven to a=0, b=0, add_sub=0, s_u=0.
- Reset or flush in any state: state IDLE, out_valid=0, in_ready=1, out_result=0, rem/quo/dvs/cnt=0. Flush outranks out_ready.

## Timing
- Reset values: in_ready=1, out_valid=0, out_result=0, all alu_* outputs=0.
- Accept in cycle T. Normal ops: N = nA + nB + 32 + nF busy cycles (nA, nB, nF each 0/1). out_valid first high in cycle T+N+1.
  - Unsigned ops: T+33.
  - Worst case: T+36.
- Div-by-zero and signed-overflow: out_valid in T+1.
- in_ready=0 from T+1 until the cycle after the out handshake. No new request is accepted in the handshake cycle.
- out_valid is registered. out_result does not change while out_valid=1.

## Test plan
- DIVU 100/7, out_ready=1 -> out_result=14 (0x0000000E), out_valid first at T+33, in_ready low T+1..T+33.
- DIV -7/2 -> 0xFFFFFFFD at T+35. REM -7/2 -> 0xFFFFFFFF at T+35. REM 7/-2 -> 1 at T+34.
- DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF; REMU 0xFFFFFFFF/0x80000000 -> 0x7FFFFFFF (exercises top-bit path).
- DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same operands -> 0; each with out_valid at T+1.
- out_ready low for 10 cycles in DONE -> out_valid and out_result stable, in_ready=0; the handshake then returns to IDLE with in_ready=1 next cycle.
- rst_n low mid-STEP (cnt=15) -> out_valid=0 and in_ready=1 immediately; flush at cnt=15 -> IDLE next cycle; the next DIVU 9/3 -> 3 with normal latency.
